// File: rtl/adder_sched_if.sv
// rtl/adder_sched_if.sv - requester-side request/response bundle for adder_sched
//
// Purpose: groups the per-requester request and response handshakes.
// master: the requesters (drive req_valid/req_a/req_b/rsp_ack).
// slave:  adder_sched (drives req_ready/rsp_valid/rsp_data).
//   req_valid [NREQ]            operand request per requester
//   req_a/b   [NREQ*WIDTH]      operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready [NREQ]            grant, at most one bit high
//   rsp_valid [NREQ]            result held for requester i
//   rsp_data  [NREQ*(WIDTH+1)]  result, requester i at [i*(WIDTH+1) +: WIDTH+1]
//   rsp_ack   [NREQ]            requester i consumes its result
interface adder_sched_if #(
    parameter int WIDTH = 10,
    parameter int NREQ  = 4
) ();
    logic [NREQ-1:0]             req_valid;
    logic [NREQ*WIDTH-1:0]       req_a;
    logic [NREQ*WIDTH-1:0]       req_b;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             rsp_valid;
    logic [NREQ*(WIDTH+1)-1:0]   rsp_data;
    logic [NREQ-1:0]             rsp_ack;

    modport master (
        output req_valid, req_a, req_b, rsp_ack,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ack,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/adder_sched.sv
// rtl/adder_sched.sv - round-robin scheduler sharing one pipelined adder among NREQ requesters
//
// Purpose: grants one eligible requester per cycle, registers its operands
// onto the shared adder, tracks the requester id alongside the adder latency
// and parks each sum in a per-requester result slot until acknowledged.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   rif          request/response bundle (slave side)
//   add_a, add_b registered operands to the shared adder
//   add_c        adder sum, LAT cycles after the operands change
//   busy         any requester has an operation pending
//   issue_count  operations issued since reset, wraps at 16 bits
module adder_sched #(
    parameter int WIDTH = 10,
    parameter int NREQ  = 4,
    parameter int LAT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    adder_sched_if.slave       rif,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    input  logic [WIDTH:0]     add_c,
    output logic               busy,
    output logic [15:0]        issue_count
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]             ptr_q, ptr_d;
    logic [NREQ-1:0]            pending_q, pending_d;
    logic [NREQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [NREQ*(WIDTH+1)-1:0]  rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0]           add_a_q, add_a_d;
    logic [WIDTH-1:0]           add_b_q, add_b_d;
    logic [15:0]                issue_count_q, issue_count_d;
    logic [LAT:0]               tag_vld_q, tag_vld_d;
    logic [LAT:0][IDW-1:0]      tag_id_q, tag_id_d;

    logic [NREQ-1:0]            eligible;
    logic [NREQ-1:0]            grant;
    logic [NREQ-1:0]            ack_fire;
    logic [IDW-1:0]             gnt_id;
    logic                       xfer;

    // Round-robin search starting at ptr_q; the first eligible requester wins.
    always_comb begin : arbitrate
        logic [IDW:0]   pos;
        logic [IDW-1:0] idx;
        logic           found;
        pos      = '0;
        idx      = '0;
        found    = 1'b0;
        eligible = rif.req_valid & ~pending_q;
        grant    = '0;
        gnt_id   = '0;
        for (int off = 0; off < NREQ; off++) begin
            pos = {1'b0, ptr_q} + (IDW+1)'(off);
            if (pos >= (IDW+1)'(NREQ)) begin
                pos = pos - (IDW+1)'(NREQ);
            end
            idx = pos[IDW-1:0];
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = idx;
            end
        end
        if (reset) begin
            grant = '0;
        end
    end

    // A grant is only raised for a valid requester, so any grant is a transfer.
    assign xfer     = |grant;
    assign ack_fire = rif.rsp_ack & rsp_valid_q;

    always_comb begin
        ptr_d         = ptr_q;
        add_a_d       = add_a_q;
        add_b_d       = add_b_q;
        issue_count_d = issue_count_q;
        // A requester cannot be granted while pending, and its slot cannot be
        // refilled before it is acked, so set/clear never collide on one bit.
        pending_d     = (pending_q & ~ack_fire) | grant;
        rsp_valid_d   = rsp_valid_q & ~ack_fire;
        rsp_data_d    = rsp_data_q;

        if (xfer) begin
            ptr_d         = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            add_a_d       = rif.req_a[gnt_id*WIDTH +: WIDTH];
            add_b_d       = rif.req_b[gnt_id*WIDTH +: WIDTH];
            issue_count_d = issue_count_q + 16'd1;
        end

        // Tag stage 0 lines up with the operands; stage LAT with add_c.
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = xfer;
        tag_id_d[0]  = gnt_id;
        for (int s = 1; s <= LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        if (tag_vld_q[LAT]) begin
            rsp_valid_d[tag_id_q[LAT]] = 1'b1;
            rsp_data_d[tag_id_q[LAT]*(WIDTH+1) +: WIDTH+1] = add_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q         <= '0;
            pending_q     <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            add_a_q       <= '0;
            add_b_q       <= '0;
            issue_count_q <= '0;
            tag_vld_q     <= '0;
            tag_id_q      <= '0;
        end else begin
            ptr_q         <= ptr_d;
            pending_q     <= pending_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            issue_count_q <= issue_count_d;
            tag_vld_q     <= tag_vld_d;
            tag_id_q      <= tag_id_d;
        end
    end

    assign rif.req_ready = grant;
    assign rif.rsp_valid = rsp_valid_q;
    assign rif.rsp_data  = rsp_data_q;
    assign add_a         = add_a_q;
    assign add_b         = add_b_q;
    assign busy          = |pending_q;
    assign issue_count   = issue_count_q;
endmodule
